// File: rtl/alpaca_consts_pkg.sv
// Shared build-time constants for the ADC-to-OSPFB capture path.
package alpaca_consts_pkg;
  localparam int FFT_LEN_DEFAULT = 2048;
  localparam int FRAMES_DEFAULT  = 32;
endpackage

// File: rtl/alpaca_dtypes_pkg.sv
// Shared datatypes for the OSPFB output stream and its capture sink.
package alpaca_dtypes_pkg;
  typedef enum logic [1:0] {IDLE, SYNC, CAP, FULL} capture_state_t;

  typedef struct packed {
    logic [31:0] re;
    logic [31:0] im;
  } sample_t;

  localparam int SAMPLE_WID = $bits(sample_t);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/capture_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port (read-old-data).
module capture_sdp_ram #(
  parameter int DATA_WID = 64,
  parameter int DEPTH    = 1024,
  parameter int AW       = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [AW-1:0]       wr_addr,
  input  logic [DATA_WID-1:0] wr_data,
  input  logic [AW-1:0]       rd_addr,
  output logic [DATA_WID-1:0] rd_data
);
  logic [DATA_WID-1:0] mem [DEPTH];

  // NOTE: the array has no reset so it maps onto block RAM; only the output register is reset.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= '0;
    else        rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/axis_frame_capture.sv
// AXI-Stream sink that stores FRAMES complete, well-framed FFT frames into RAM
// and counts framing errors; frames that break framing are discarded and overwritten.
module axis_frame_capture
  import alpaca_dtypes_pkg::*;
#(
  parameter int  DATA_WID = alpaca_dtypes_pkg::SAMPLE_WID,
  parameter int  FFT_LEN  = alpaca_consts_pkg::FFT_LEN_DEFAULT,
  parameter int  FRAMES   = alpaca_consts_pkg::FRAMES_DEFAULT,
  localparam int DEPTH    = FFT_LEN * FRAMES,
  localparam int AW       = $clog2(DEPTH),
  localparam int FW       = $clog2(FRAMES + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                clear,
  input  logic [DATA_WID-1:0] s_axis_tdata,
  input  logic                s_axis_tvalid,
  input  logic                s_axis_tuser,
  input  logic                s_axis_tlast,
  output logic                s_axis_tready,
  input  logic [AW-1:0]       rd_addr,
  output logic [DATA_WID-1:0] rd_data,
  output logic                full,
  output logic [FW-1:0]       frames_done,
  output logic [15:0]         err_tlast_unexpected,
  output logic [15:0]         err_tlast_missing
);
  localparam int IW = $clog2(FFT_LEN);
  localparam logic [IW-1:0] IDX_LAST = IW'(FFT_LEN - 1);

  capture_state_t state, state_nxt;
  logic [IW-1:0]  idx, idx_nxt;
  logic [AW-1:0]  base, base_nxt;
  logic [FW-1:0]  frames_q, frames_nxt;
  logic [15:0]    err_u, err_u_nxt, err_m, err_m_nxt;
  logic           tready_q, full_q;
  logic           we;
  logic [AW-1:0]  wr_addr;
  logic           beat;

  assign beat = s_axis_tvalid & tready_q;

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    base_nxt   = base;
    frames_nxt = frames_q;
    err_u_nxt  = err_u;
    err_m_nxt  = err_m;
    we         = 1'b0;
    wr_addr    = base + AW'(idx);

    if (state != FULL && (clear || !en)) begin
      state_nxt  = IDLE;
      idx_nxt    = '0;
      base_nxt   = '0;
      frames_nxt = '0;
      err_u_nxt  = '0;
      err_m_nxt  = '0;
    end else begin
      case (state)
        IDLE: state_nxt = SYNC;
        SYNC: begin
          if (beat && s_axis_tuser) begin
            we        = 1'b1;
            wr_addr   = base;
            idx_nxt   = IW'(1);
            state_nxt = CAP;
          end
        end
        CAP: begin
          if (beat) begin
            we = 1'b1;
            if (s_axis_tuser) begin
              // A new start mid-frame restarts the frame in place.
              err_u_nxt = sat_inc16(err_u);
              wr_addr   = base;
              idx_nxt   = IW'(1);
            end else if (idx == IDX_LAST) begin
              idx_nxt = '0;
              if (s_axis_tlast) begin
                base_nxt   = base + AW'(FFT_LEN);
                frames_nxt = frames_q + FW'(1);
                state_nxt  = (frames_nxt == FW'(FRAMES)) ? FULL : SYNC;
              end else begin
                err_m_nxt = sat_inc16(err_m);
                state_nxt = SYNC;
              end
            end else if (s_axis_tlast) begin
              err_u_nxt = sat_inc16(err_u);
              idx_nxt   = '0;
              state_nxt = SYNC;
            end else begin
              idx_nxt = idx + IW'(1);
            end
          end
        end
        FULL: begin
          if (clear) begin
            state_nxt  = IDLE;
            idx_nxt    = '0;
            base_nxt   = '0;
            frames_nxt = '0;
            err_u_nxt  = '0;
            err_m_nxt  = '0;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      base     <= '0;
      frames_q <= '0;
      err_u    <= '0;
      err_m    <= '0;
      tready_q <= 1'b0;
      full_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      base     <= base_nxt;
      frames_q <= frames_nxt;
      err_u    <= err_u_nxt;
      err_m    <= err_m_nxt;
      tready_q <= 1'b1;
      full_q   <= (state_nxt == FULL);
    end
  end

  assign s_axis_tready        = tready_q;
  assign full                 = full_q;
  assign frames_done          = frames_q;
  assign err_tlast_unexpected = err_u;
  assign err_tlast_missing    = err_m;

  capture_sdp_ram #(
    .DATA_WID (DATA_WID),
    .DEPTH    (DEPTH),
    .AW       (AW)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (we),
    .wr_addr (wr_addr),
    .wr_data (s_axis_tdata),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );
endmodule

// File: tb/tb_axis_frame_capture.sv
// Scoreboard bench for axis_frame_capture with FFT_LEN=8, FRAMES=4.
module tb_axis_frame_capture;
  localparam int DW = 64;
  localparam int FL = 8;
  localparam int FR = 4;
  localparam int AW = 5;
  localparam int FW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          en = 1'b0;
  logic          clear = 1'b0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tuser = 1'b0;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tready;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic          full;
  logic [FW-1:0] frames_done;
  logic [15:0]   err_tlast_unexpected;
  logic [15:0]   err_tlast_missing;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];
  logic rd_v = 1'b0;
  logic rd_v_d;
  logic mon_tready = 1'b0;
  int   tready_low = 0;

  always #5 clk = ~clk;

  axis_frame_capture #(.DATA_WID(DW), .FFT_LEN(FL), .FRAMES(FR)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .en                   (en),
    .clear                (clear),
    .s_axis_tdata         (s_axis_tdata),
    .s_axis_tvalid        (s_axis_tvalid),
    .s_axis_tuser         (s_axis_tuser),
    .s_axis_tlast         (s_axis_tlast),
    .s_axis_tready        (s_axis_tready),
    .rd_addr              (rd_addr),
    .rd_data              (rd_data),
    .full                 (full),
    .frames_done          (frames_done),
    .err_tlast_unexpected (err_tlast_unexpected),
    .err_tlast_missing    (err_tlast_missing)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_v_d <= 1'b0;
    else        rd_v_d <= rd_v;
  end

  // Monitor: each read response pops the expectation queued when it was issued.
  always @(negedge clk) begin
    if (rd_v_d) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_data: response %0h with no queued expectation", rd_data);
      end else begin
        check("rd_data", rd_data, exp_q.pop_front());
      end
    end
    if (mon_tready && !s_axis_tready) tready_low++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    s_axis_tvalid = 1'b0;
    repeat (n) step();
  endtask

  task automatic beat(input logic [63:0] d, input logic u, input logic l);
    s_axis_tdata  = d;
    s_axis_tuser  = u;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    step();
    s_axis_tvalid = 1'b0;
  endtask

  task automatic frame(input int first, input bit gaps);
    for (int i = 0; i < FL; i++) begin
      if (gaps) idle(int'($urandom_range(0, 1)));
      beat(64'(first + i), i == 0, i == FL - 1);
    end
  endtask

  task automatic read_word(input int addr, input int exp);
    rd_addr = AW'(addr);
    rd_v    = 1'b1;
    exp_q.push_back(DW'(exp));
    step();
    rd_v = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 5) begin
      step();
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL read_drain: %0d responses outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic status(input string tag, input logic f, input int nf, input int eu, input int em);
    check({tag, "_full"}, full, f);
    check({tag, "_frames_done"}, frames_done, 64'(nf));
    check({tag, "_err_unexpected"}, err_tlast_unexpected, 64'(eu));
    check({tag, "_err_missing"}, err_tlast_missing, 64'(em));
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1);
  end

  initial begin
    #1 rst_n = 1'b0;
    #2;
    status("reset", 1'b0, 0, 0, 0);
    check("reset_tready", s_axis_tready, 1'b0);
    check("reset_rd_data", rd_data, 64'd0);
    #20 rst_n = 1'b1;
    step();
    check("tready_after_reset", s_axis_tready, 1'b1);
    mon_tready = 1'b1;

    // Four clean back-to-back frames, data = running count.
    en = 1'b1;
    idle(1);
    for (int f = 0; f < FR - 1; f++) frame(f * FL, 1'b0);
    for (int i = 0; i < FL - 1; i++) beat(64'(24 + i), i == 0, 1'b0);
    check("full_before_last_beat", full, 1'b0);
    beat(64'd31, 1'b0, 1'b1);
    status("clean", 1'b1, 4, 0, 0);
    beat(64'hAA, 1'b1, 1'b0);
    beat(64'hAB, 1'b0, 1'b1);
    for (int i = 0; i < FR * FL; i++) read_word(i, i);
    drain();

    pulse_clear();
    status("after_clear", 1'b0, 0, 0, 0);

    // Mid-frame start, early tlast, missing tlast.
    idle(2);
    beat(64'd105, 1'b0, 1'b0);
    beat(64'd106, 1'b0, 1'b0);
    beat(64'd107, 1'b0, 1'b1);
    frame(200, 1'b0);
    check("midstart_frames_done", frames_done, 64'd1);
    beat(64'd300, 1'b1, 1'b0);
    beat(64'd301, 1'b0, 1'b0);
    beat(64'd302, 1'b0, 1'b0);
    beat(64'd303, 1'b0, 1'b1);
    status("early_tlast", 1'b0, 1, 1, 0);
    frame(400, 1'b0);
    check("after_early_frames_done", frames_done, 64'd2);
    for (int i = 0; i < FL; i++) beat(64'(500 + i), i == 0, 1'b0);
    status("missing_tlast", 1'b0, 2, 1, 1);
    beat(64'd508, 1'b0, 1'b0);
    frame(600, 1'b0);
    frame(700, 1'b0);
    status("errors_run", 1'b1, 4, 1, 1);
    for (int i = 0; i < FL; i++) read_word(i, 200 + i);
    for (int i = 0; i < FL; i++) read_word(8 + i, 400 + i);
    for (int i = 0; i < FL; i++) read_word(16 + i, 600 + i);
    for (int i = 0; i < FL; i++) read_word(24 + i, 700 + i);
    drain();

    // Clean frames with random tvalid gaps.
    pulse_clear();
    idle(2);
    for (int f = 0; f < FR; f++) frame(f * FL, 1'b1);
    status("gaps", 1'b1, 4, 0, 0);
    for (int i = 0; i < FR * FL; i++) read_word(i, i);
    drain();
    check("tready_low_cycles", 64'(tready_low), 64'd0);

    // Async reset mid-frame 2, then recapture from RAM[0].
    pulse_clear();
    idle(2);
    frame(1000, 1'b0);
    beat(64'd1008, 1'b1, 1'b0);
    beat(64'd1009, 1'b0, 1'b0);
    beat(64'd1010, 1'b0, 1'b0);
    check("pre_reset_frames_done", frames_done, 64'd1);
    mon_tready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    status("midframe_reset", 1'b0, 0, 0, 0);
    check("midframe_reset_tready", s_axis_tready, 1'b0);
    check("midframe_reset_rd_data", rd_data, 64'd0);
    #8 rst_n = 1'b1;
    step();
    mon_tready = 1'b1;
    for (int f = 0; f < FR; f++) frame(2000 + f * FL, 1'b0);
    status("recapture", 1'b1, 4, 0, 0);
    read_word(0, 2000);
    read_word(9, 2009);
    read_word(31, 2031);
    drain();

    mon_tready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    status("full_reset", 1'b0, 0, 0, 0);
    #8 rst_n = 1'b1;
    step();
    check("full_reset_stays_clear", full, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
